iq_mixer_decimator: RTL
=======================

IQ_MIXER_DECIMATOR -- requirements
Module: iq_mixer_decimator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: signed RF input sample width.
REQ-002 SHALL have parameter DATA_WIDTH, default 7: signed NCO sine/cosine width.
REQ-003 SHALL have parameter DECIM_LOG2, default 6: decimation ratio DECIM = 2^DECIM_LOG2.
REQ-004 SHALL have parameter OUT_WIDTH, default 12: signed I/Q output width; legal range is OUT_WIDTH <= ACC_W.
REQ-005 SHALL have port clk, input, 1: single clock.
REQ-006 SHALL have port arst_n, input, 1: reset, asynchronous assert, active-low (already decided).
REQ-007 SHALL have port sample_clk_ce, input, 1: sample-rate clock enable.
REQ-008 SHALL have port sync_clr, input, 1: synchronous realign/clear.
REQ-009 SHALL have port rf_in, input, IN_WIDTH, signed: RF sample, valid when sample_clk_ce=1.
REQ-010 SHALL have port sinewave, input, DATA_WIDTH, signed: NCO sine, sampled with rf_in.
REQ-011 SHALL have port cosinewave, input, DATA_WIDTH, signed: NCO cosine, sampled with rf_in.
REQ-012 SHALL have port i_out, output, OUT_WIDTH, signed: decimated in-phase result.
REQ-013 SHALL have port q_out, output, OUT_WIDTH, signed: decimated quadrature result.
REQ-014 SHALL have port out_valid, output, 1: one-clk pulse marking new i_out/q_out.

Function
REQ-015 SHALL compute, on every clk edge with sample_clk_ce=1, registered products prod_i <= rf_in*cosinewave and prod_q <= -(rf_in*sinewave), each signed, PROD_W = IN_WIDTH+DATA_WIDTH bits, exact with no overflow.
REQ-016 SHALL use accumulators acc_i and acc_q that are signed and ACC_W = PROD_W+DECIM_LOG2 bits wide, sign-extending products, with no wrap possible.
REQ-017 SHALL use a sample counter cnt with width DECIM_LOG2 and a reset value of 0.
REQ-018 SHALL, on a ce edge with cnt != DECIM-1, update acc <= acc + prod (the prod value registered at the previous ce edge) and cnt <= cnt+1.
REQ-019 SHALL, on a ce edge with cnt == DECIM-1 (dump), compute sum = acc + prod, load i_out/q_out <= sum[ACC_W-1:ACC_W-OUT_WIDTH] (truncation, floor), and update acc <= 0, cnt <= 0, out_valid <= 1.
REQ-020 SHALL drive out_valid high for exactly one clk after each dump edge and low at all other times; i_out/q_out SHALL hold their value between dumps.
REQ-021 SHALL hold all state (products, acc, cnt) on clk edges where sample_clk_ce=0.
REQ-022 SHALL, when sync_clr=1 on a clk edge, regardless of sample_clk_ce, update prod, acc, and cnt to 0 and out_valid to 0, and leave i_out/q_out unchanged; sync_clr SHALL take priority over a coincident dump.
REQ-023 SHALL have a first dump after reset or sync_clr that contains DECIM-1 real products (the first accumulated prod is the cleared 0); subsequent dumps SHALL contain DECIM products.
REQ-024 SHALL have a pipeline latency of 1 ce from sample to product and 1 clk from dump edge to out_valid/data.

Reset
REQ-025 SHALL, when arst_n=0, immediately and asynchronously force prod_i, prod_q, acc_i, acc_q, cnt, i_out, q_out, and out_valid to 0.
REQ-026 SHALL resume on the first ce edge after arst_n deasserts, with behaviour identical to REQ-023; a reset mid-accumulation SHALL discard the partial sum and SHALL NOT produce an out_valid pulse.

Verification
REQ-027 SHALL be verified with: defaults, ce every clk, rf_in=+100, cosinewave=+63, sinewave=0 -> 1st dump i_out=775 (396900>>9), q_out=0; 2nd dump i_out=787, q_out=0; out_valid pulses spaced 64 clk.
REQ-028 SHALL be verified with: rf_in=-128, cosinewave=-64, sinewave=-64 -> steady-state i_out=+1024, q_out=-1024, no overflow.
REQ-029 SHALL be verified with: ce every 4th clk, constant inputs as REQ-027 -> identical values, out_valid period 256 clk, each pulse exactly 1 clk wide.
REQ-030 SHALL be verified with: arst_n low after 30 samples -> all outputs 0 at once; after release, the next out_valid arrives 64 ce later with i_out=775.
REQ-031 SHALL be verified with: sync_clr coincident with the dump ce (cnt=63) -> no out_valid, i_out/q_out retain previous value, next dump 64 ce later with DECIM-1 products.
REQ-032 SHALL be verified with: rf_in alternating +100/-100, cosinewave=+63 -> steady-state i_out=0, q_out=0.

Source files
------------

// File: rtl/iq_mixer_decimator.sv
// Quadrature mixer followed by an integrate-and-dump decimator.
// Each sample is multiplied by the NCO cosine / negated sine, and 2^DECIM_LOG2 products are summed per output.
module iq_mixer_decimator #(
  parameter int IN_WIDTH   = 8,
  parameter int DATA_WIDTH = 7,
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_WIDTH  = 12
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         sample_clk_ce,
  input  logic                         sync_clr,
  input  logic signed [IN_WIDTH-1:0]   rf_in,
  input  logic signed [DATA_WIDTH-1:0] sinewave,
  input  logic signed [DATA_WIDTH-1:0] cosinewave,
  output logic signed [OUT_WIDTH-1:0]  i_out,
  output logic signed [OUT_WIDTH-1:0]  q_out,
  output logic                         out_valid
);

  localparam int PROD_W = IN_WIDTH + DATA_WIDTH;
  localparam int ACC_W  = PROD_W + DECIM_LOG2;

  function automatic logic signed [PROD_W-1:0] sext_rf(input logic signed [IN_WIDTH-1:0] x);
    return {{(PROD_W-IN_WIDTH){x[IN_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [PROD_W-1:0] sext_nco(input logic signed [DATA_WIDTH-1:0] x);
    return {{(PROD_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] x);
    return {{DECIM_LOG2{x[PROD_W-1]}}, x};
  endfunction

  // Keep the top OUT_WIDTH bits of the sum: floor division by 2^(ACC_W-OUT_WIDTH).
  function automatic logic signed [OUT_WIDTH-1:0] trunc_out(input logic signed [ACC_W-1:0] s);
    return OUT_WIDTH'(s >>> (ACC_W - OUT_WIDTH));
  endfunction

  logic signed [PROD_W-1:0]   mult_i, mult_q;
  logic signed [PROD_W-1:0]   prod_i_p0, prod_q_p0;
  logic signed [ACC_W-1:0]    acc_i_p1, acc_q_p1;
  logic signed [ACC_W-1:0]    sum_i, sum_q;
  logic        [DECIM_LOG2-1:0] cnt;
  logic                       dump;

  // The widest product (-2^(IN-1) * -2^(DATA-1)) still fits PROD_W, even after negation.
  assign mult_i = sext_rf(rf_in) * sext_nco(cosinewave);
  assign mult_q = -(sext_rf(rf_in) * sext_nco(sinewave));

  assign sum_i = acc_i_p1 + sext_prod(prod_i_p0);
  assign sum_q = acc_q_p1 + sext_prod(prod_q_p0);
  assign dump  = &cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prod_i_p0 <= '0;
      prod_q_p0 <= '0;
      acc_i_p1  <= '0;
      acc_q_p1  <= '0;
      cnt       <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sync_clr) begin
        prod_i_p0 <= '0;
        prod_q_p0 <= '0;
        acc_i_p1  <= '0;
        acc_q_p1  <= '0;
        cnt       <= '0;
      end else if (sample_clk_ce) begin
        // stage p0: mixer products
        prod_i_p0 <= mult_i;
        prod_q_p0 <= mult_q;
        // stage p1: integrate, or dump to the output registers
        cnt <= cnt + DECIM_LOG2'(1);
        if (dump) begin
          i_out     <= trunc_out(sum_i);
          q_out     <= trunc_out(sum_q);
          acc_i_p1  <= '0;
          acc_q_p1  <= '0;
          out_valid <= 1'b1;
        end else begin
          acc_i_p1 <= sum_i;
          acc_q_p1 <= sum_q;
        end
      end
    end
  end

endmodule
